bp_me_mem_responder: RTL and testbench
======================================

# bp_me_mem_responder

Serial BedRock memory-side responder: terminates the mem_fwd stream issued by a core or cache engine and returns the matching mem_rev stream. Holds a flop-array backing store, executes one request at a time (reads, writes, sub-word writes, multi-beat blocks) and echoes the request header on the response. Sits at the far end of a core's mem_fwd/mem_rev port, as a tightly-coupled scratchpad or as the bench memory for core-level tests.

## Interface
- fill_width_p, 64: bits per data beat on both streams; power of two, ≥ 64
- els_p, 512: backing-store depth in fill_width_p words; power of two
- block_width_p, 512: largest legal transfer (bits); multiple of fill_width_p
- paddr_width_p, 40: header address width
- clk_i  in  1  clock, all state on posedge
- reset_n_i  in  1  asynchronous, active-low reset
- mem_fwd_header_i  in  bp_bedrock_mem_header_s  msg_type, size (log2 bytes), addr, payload
- mem_fwd_data_i  in  fill_width_p  request beat data
- mem_fwd_v_i  in  1  request beat valid
- mem_fwd_ready_and_o  out  1  request beat accepted when v & ready
- mem_rev_header_o  out  bp_bedrock_mem_header_s  response header
- mem_rev_data_o  out  fill_width_p  response beat data
- mem_rev_v_o  out  1  response beat valid
- mem_rev_ready_and_i  in  1  downstream ready; beat transfers when v & ready

## Operation
- beats = max(1, (8<<size)/fill_width_p); the header is presented on every beat of a message and sampled on the first.
- Word index: base = addr[lg(fill_width_p/8) +: lg(els_p)] aligned down to the beat count; beat k uses (base+k) mod els_p. Upper address bits are ignored (aliasing).
- FSM states: e_recv, e_send.
  - e_recv: ready_and_o=1. Each accepted beat of a write (e_bedrock_mem_wr, e_bedrock_mem_uc_wr) updates its word on that clock edge.
  - e_recv, sub-fill size: byte mask = (1<<size) bytes at addr[lg(fill_width_p/8)-1:0] (naturally aligned). Only masked lanes are taken from the same lanes of mem_fwd_data_i.
  - e_recv: when the last request beat is accepted, the header is captured and the FSM moves to e_send.
  - e_send: ready_and_o=0. Response header equals the captured header.
  - e_send, reads (e_bedrock_mem_rd, e_bedrock_mem_uc_rd): emit `beats` beats, beat k = word (base+k) read combinationally from the array.
  - e_send, sub-fill read: the addressed bytes are replicated across fill_width_p.
  - e_send, writes: emit one beat, data zero.
  - e_send, any other msg_type (amo, etc.): one beat, data zero, memory untouched.
  - e_send exit: after the last response beat transfers, return to e_recv.
- One outstanding request; no reordering.
- Backing store is not reset; contents are undefined until written.

## Timing
- reset_n_i low (asynchronous): state=e_recv, beat counters=0, mem_fwd_ready_and_o=0, mem_rev_v_o=0, mem_rev_header_o=0, mem_rev_data_o=0. ready_and_o rises on the first posedge after reset_n_i deasserts.
- Reset mid-message: the partial request is discarded and any pending response is dropped. Words already written by accepted beats keep their values.
- Single-beat request accepted at edge N: mem_rev_v_o=1 from cycle N+1. Next request accepted no earlier than the edge after the final response beat (minimum 2-cycle turnaround).
- N-beat request: beats accepted back-to-back with no bubbles; response beats issue back-to-back while mem_rev_ready_and_i=1.
- mem_rev_v_o, once raised, holds with header and data stable until the transfer; it never depends combinationally on mem_rev_ready_and_i.
- Read of a word written by the same request's beats (cannot occur) is undefined. A read in the request following a write sees the new data.
- Beat counter is lg(block_width_p/fill_width_p)+1 bits; wraps to 0 at message end.

## Test plan
- Reset: hold reset_n_i=0 with mem_fwd_v_i=1 -> ready_and_o=0, mem_rev_v_o=0. Release -> ready_and_o=1 next edge.
- uc_wr size=3, addr 0x80, data 0xDEADBEEF_01234567; then uc_rd same addr -> write ack (1 beat, data 0, header echoed) at N+1; read returns 0xDEADBEEF_01234567.
- uc_wr size=0, addr 0x83, data replicated 0xAA over an all-zero word -> subsequent 8-byte read returns 0x00000000_AA000000. A size=0 read of 0x83 returns 0xAAAA…AA.
- 64B e_bedrock_mem_wr, 8 beats 0..7 at addr 0x1000; then rd 64B -> 8 response beats 0..7 in order, no bubbles with ready held 1.
- Backpressure: mem_rev_ready_and_i toggles 1,0,0,1 during an 8-beat read -> each beat held stable while stalled, all 8 delivered, ready_and_o stays 0 until the last beat.
- Aliasing/abort: write addr 0x0 then read addr els_p*8 -> same data. Assert reset_n_i after beat 3 of a 64B write -> beats 0–3 written, beats 4–7 unchanged, no response.

Source files
------------

// File: rtl/bp_me_mem_responder.sv
// bp_me_mem_responder: serial BedRock memory-side responder backed by a flop
// array. Accepts one mem_fwd message at a time, answers with one mem_rev message.
//   clk_i, reset_n_i          : clock, async active-low reset
//   mem_fwd_header_i/data_i   : request header (held on every beat) and beat data
//   mem_fwd_v_i/ready_and_o   : request beat handshake
//   mem_rev_header_o/data_o   : response header (echo of request) and beat data
//   mem_rev_v_o/ready_and_i   : response beat handshake

package bp_me_mem_pkg;

    localparam int paddr_width_gp = 40;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef struct packed {
        logic [15:0]               payload;
        logic [paddr_width_gp-1:0] addr;
        logic [2:0]                size;
        bp_bedrock_mem_type_e      msg_type;
    } bp_bedrock_mem_header_s;

endpackage

module bp_me_mem_responder
    import bp_me_mem_pkg::*;
#(
    parameter int fill_width_p  = 64,
    parameter int els_p         = 512,
    parameter int block_width_p = 512,
    parameter int paddr_width_p = paddr_width_gp
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,

    input  bp_bedrock_mem_header_s  mem_fwd_header_i,
    input  logic [fill_width_p-1:0] mem_fwd_data_i,
    input  logic                    mem_fwd_v_i,
    output logic                    mem_fwd_ready_and_o,

    output bp_bedrock_mem_header_s  mem_rev_header_o,
    output logic [fill_width_p-1:0] mem_rev_data_o,
    output logic                    mem_rev_v_o,
    input  logic                    mem_rev_ready_and_i
);

    localparam int fill_bytes_lp    = fill_width_p / 8;
    localparam int lg_fill_bytes_lp = $clog2(fill_bytes_lp);
    localparam int lg_els_lp        = $clog2(els_p);
    localparam int max_beats_lp     = block_width_p / fill_width_p;
    localparam int cnt_w_lp         = $clog2(max_beats_lp) + 1;

    if (lg_fill_bytes_lp + lg_els_lp > paddr_width_p
        || paddr_width_p != paddr_width_gp) begin : g_bad_cfg
        $error("bp_me_mem_responder: address width too small");
    end

    typedef logic [lg_els_lp-1:0] idx_t;
    typedef logic [cnt_w_lp-1:0]  cnt_t;

    // Beats in a message: one for anything up to a full fill word.
    function automatic cnt_t beats_f(input logic [2:0] sz);
        if (int'(sz) <= lg_fill_bytes_lp) begin
            return cnt_t'(1);
        end
        return cnt_t'(1) << (int'(sz) - lg_fill_bytes_lp);
    endfunction

    // Block base: word index aligned down to the beat count.
    function automatic idx_t base_f(input idx_t idx, input cnt_t nb);
        idx_t m;
        m = idx_t'(nb) - idx_t'(1);
        return idx & ~m;
    endfunction

    typedef enum logic {
        e_recv,
        e_send
    } state_e;

    state_e                 state_r, state_n;
    cnt_t                   cnt_r, cnt_n;
    bp_bedrock_mem_header_s hdr_r, hdr_n;
    logic                   live_r;

    logic [fill_width_p-1:0] mem [els_p];

    // Request side: header is live on every beat, so decode it directly.
    cnt_t                    fwd_beats;
    idx_t                    fwd_idx;
    logic                    fwd_fire;
    logic                    fwd_last;
    logic                    fwd_is_wr;
    logic [fill_bytes_lp-1:0] byte_mask;
    logic [fill_width_p-1:0] wr_word;

    assign fwd_beats = beats_f(mem_fwd_header_i.size);
    assign fwd_idx   = base_f(
        mem_fwd_header_i.addr[lg_fill_bytes_lp +: lg_els_lp],
        fwd_beats) + idx_t'(cnt_r);
    assign fwd_fire  = mem_fwd_v_i & mem_fwd_ready_and_o;
    assign fwd_last  = (cnt_r == fwd_beats - cnt_t'(1));
    assign fwd_is_wr =
        (mem_fwd_header_i.msg_type == e_bedrock_mem_wr)
        | (mem_fwd_header_i.msg_type == e_bedrock_mem_uc_wr);

    // Sub-fill writes touch only the naturally aligned 1<<size bytes.
    always_comb begin
        int sz;
        int off;
        sz  = int'(mem_fwd_header_i.size);
        off = int'(mem_fwd_header_i.addr[lg_fill_bytes_lp-1:0]);
        byte_mask = '0;
        for (int i = 0; i < fill_bytes_lp; i++) begin
            if (sz >= lg_fill_bytes_lp) begin
                byte_mask[i] = 1'b1;
            end else begin
                byte_mask[i] = ((i >> sz) == (off >> sz));
            end
        end
    end

    always_comb begin
        wr_word = mem[fwd_idx];
        for (int i = 0; i < fill_bytes_lp; i++) begin
            if (byte_mask[i]) begin
                wr_word[8*i +: 8] = mem_fwd_data_i[8*i +: 8];
            end
        end
    end

    // Backing store has no reset; beats accepted before a reset stay written.
    always_ff @(posedge clk_i) begin
        if (fwd_fire && fwd_is_wr) begin
            mem[fwd_idx] <= wr_word;
        end
    end

    // Response side: everything comes from the captured header.
    cnt_t                    snd_beats;
    idx_t                    rd_idx;
    logic [fill_width_p-1:0] rd_word;
    logic [fill_width_p-1:0] rd_data;
    logic                    snd_is_rd;
    logic                    snd_last;
    logic                    rev_fire;

    assign snd_beats = beats_f(hdr_r.size);
    assign rd_idx    = base_f(
        hdr_r.addr[lg_fill_bytes_lp +: lg_els_lp],
        snd_beats) + idx_t'(cnt_r);
    assign rd_word   = mem[rd_idx];
    assign snd_is_rd =
        (hdr_r.msg_type == e_bedrock_mem_rd)
        | (hdr_r.msg_type == e_bedrock_mem_uc_rd);
    assign snd_last  = (cnt_r == snd_beats - cnt_t'(1));
    assign rev_fire  = mem_rev_v_o & mem_rev_ready_and_i;

    // Sub-fill reads replicate the addressed chunk across the beat.
    always_comb begin
        int sz;
        int chunk;
        int off;
        sz    = int'(hdr_r.size);
        chunk = 1 << sz;
        off   = int'(hdr_r.addr[lg_fill_bytes_lp-1:0]) & ~(chunk - 1);
        rd_data = rd_word;
        if (sz < lg_fill_bytes_lp) begin
            for (int i = 0; i < fill_bytes_lp; i++) begin
                rd_data[8*i +: 8] =
                    rd_word[8*(off + (i & (chunk - 1))) +: 8];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= e_recv;
            cnt_r   <= '0;
            hdr_r   <= '0;
            live_r  <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            hdr_r   <= hdr_n;
            live_r  <= 1'b1;
        end
    end

    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        hdr_n   = hdr_r;
        unique case (state_r)
            e_recv: begin
                if (fwd_fire) begin
                    if (fwd_last) begin
                        cnt_n   = '0;
                        hdr_n   = mem_fwd_header_i;
                        state_n = e_send;
                    end else begin
                        cnt_n = cnt_r + cnt_t'(1);
                    end
                end
            end
            e_send: begin
                if (rev_fire) begin
                    // Only reads stream multiple beats back.
                    if (!snd_is_rd || snd_last) begin
                        cnt_n   = '0;
                        state_n = e_recv;
                    end else begin
                        cnt_n = cnt_r + cnt_t'(1);
                    end
                end
            end
            default: begin
                state_n = e_recv;
            end
        endcase
    end

    // live_r keeps ready low through reset and the first edge after it.
    assign mem_fwd_ready_and_o = live_r & (state_r == e_recv);
    assign mem_rev_v_o         = (state_r == e_send);
    assign mem_rev_header_o    = (state_r == e_send) ? hdr_r : '0;
    assign mem_rev_data_o      = (state_r == e_send && snd_is_rd)
                                 ? rd_data : '0;

endmodule

// File: tb/tb_bp_me_mem_responder.sv
// tb_bp_me_mem_responder: scoreboard bench for bp_me_mem_responder.
// Drives mem_fwd messages, predicts mem_rev beats from a word model.

module tb_bp_me_mem_responder;
    import bp_me_mem_pkg::*;

    localparam int fill_w = 64;
    localparam int els    = 512;
    localparam int block  = 512;

    logic                   clk;
    logic                   rst_n;
    bp_bedrock_mem_header_s fwd_hdr;
    logic [fill_w-1:0]      fwd_data;
    logic                   fwd_v;
    logic                   fwd_rdy;
    bp_bedrock_mem_header_s rev_hdr;
    logic [fill_w-1:0]      rev_data;
    logic                   rev_v;
    logic                   rev_rdy;

    bp_me_mem_responder #(
        .fill_width_p (fill_w),
        .els_p        (els),
        .block_width_p(block),
        .paddr_width_p(40)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (rst_n),
        .mem_fwd_header_i   (fwd_hdr),
        .mem_fwd_data_i     (fwd_data),
        .mem_fwd_v_i        (fwd_v),
        .mem_fwd_ready_and_o(fwd_rdy),
        .mem_rev_header_o   (rev_hdr),
        .mem_rev_data_o     (rev_data),
        .mem_rev_v_o        (rev_v),
        .mem_rev_ready_and_i(rev_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bp_bedrock_mem_header_s h;
        logic [63:0]            d;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] model [els];
    logic [63:0] wdata [8];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          bp_en   = 0;
    int          tag_cnt = 1;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rd_exp(input logic [63:0] w,
                                           input int sz,
                                           input int off);
        logic [63:0] r;
        int n;
        int o;
        if (sz >= 3) return w;
        n = 1 << sz;
        o = off & ~(n - 1);
        r = '0;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = w[8*(o + i % n) +: 8];
        return r;
    endfunction

    // Response monitor: compares every presented beat, pops on transfer.
    always @(negedge clk) begin
        if (rst_n && rev_v) begin
            if (sb.size() == 0) begin
                chk("unexp_rev", 64'd1, 64'd0);
            end else begin
                chk("rev_hdr", 64'(rev_hdr), 64'(sb[0].h));
                chk("rev_data", rev_data, sb[0].d);
                chk("fwd_rdy_in_send", 64'(fwd_rdy), 64'd0);
                if (rev_rdy) void'(sb.pop_front());
            end
        end
    end

    // Downstream ready: held 1, or 1,0,0,1 under backpressure.
    initial begin
        int ph;
        bit pat [4];
        pat[0] = 1; pat[1] = 0; pat[2] = 0; pat[3] = 1;
        ph = 0;
        rev_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_en) begin
                rev_rdy = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                rev_rdy = 1'b1;
                ph = 0;
            end
        end
    end

    task automatic do_req(input bp_bedrock_mem_type_e t,
                          input int sz,
                          input logic [39:0] a,
                          input int abort_at);
        int nb;
        int lim;
        int base;
        int off;
        int cyc;
        bit is_wr;
        bit is_rd;
        bit ok;
        exp_t e;
        nb    = (sz <= 3) ? 1 : (1 << (sz - 3));
        lim   = (abort_at >= 0) ? abort_at : nb;
        base  = int'(a[11:3]) & ~(nb - 1);
        off   = int'(a[2:0]);
        is_wr = (t == e_bedrock_mem_wr) || (t == e_bedrock_mem_uc_wr);
        is_rd = (t == e_bedrock_mem_rd) || (t == e_bedrock_mem_uc_rd);
        fwd_hdr.msg_type = t;
        fwd_hdr.size     = 3'(sz);
        fwd_hdr.addr     = a;
        fwd_hdr.payload  = 16'(tag_cnt);
        tag_cnt++;
        e.h = fwd_hdr;
        if (abort_at < 0) begin
            if (is_rd) begin
                for (int k = 0; k < nb; k++) begin
                    e.d = rd_exp(model[(base + k) % els], sz, off);
                    sb.push_back(e);
                end
            end else begin
                e.d = '0;
                sb.push_back(e);
            end
        end
        if (is_wr) begin
            for (int k = 0; k < lim; k++) begin
                for (int i = 0; i < 8; i++) begin
                    if (sz >= 3 || (i >> sz) == (off >> sz))
                        model[(base + k) % els][8*i +: 8] =
                            wdata[k][8*i +: 8];
                end
            end
        end
        for (int k = 0; k < lim; k++) begin
            fwd_data = wdata[k];
            fwd_v = 1'b1;
            ok = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clk);
                if (fwd_rdy) begin
                    ok = 1;
                    break;
                end
            end
            @(posedge clk);
            #1;
            if (!ok) chk("accept_to", 64'd0, 64'd1);
        end
        fwd_v = 1'b0;
        if (abort_at >= 0) begin
            rst_n = 1'b0;
            #2;
            chk("abort_rev_v", 64'(rev_v), 64'd0);
            chk("abort_rdy", 64'(fwd_rdy), 64'd0);
            repeat (2) @(posedge clk);
            #1;
            rst_n = 1'b1;
            @(posedge clk);
            #1;
            chk("abort_rdy_up", 64'(fwd_rdy), 64'd1);
            chk("abort_no_rsp", 64'(rev_v), 64'd0);
            return;
        end
        chk("rsp_lat", 64'(rev_v), 64'd1);
        cyc = 0;
        while (sb.size() != 0 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        if (sb.size() != 0) begin
            chk("drain_to", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        if (!bp_en) chk("rsp_beats", 64'(cyc), 64'(is_rd ? nb : 1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout tests=%0d", n_tests);
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        fwd_v    = 1'b1;
        fwd_hdr  = '0;
        fwd_data = '1;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 64'(fwd_rdy), 64'd0);
        chk("rst_rev_v", 64'(rev_v), 64'd0);
        chk("rst_rev_hdr", 64'(rev_hdr), 64'd0);
        chk("rst_rev_data", rev_data, 64'd0);
        fwd_v = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rdy_before_edge", 64'(fwd_rdy), 64'd0);
        @(posedge clk);
        #1;
        chk("rdy_after_edge", 64'(fwd_rdy), 64'd1);

        wdata[0] = 64'hDEADBEEF_01234567;
        do_req(e_bedrock_mem_uc_wr, 3, 40'h80, -1);
        do_req(e_bedrock_mem_uc_rd, 3, 40'h80, -1);

        wdata[0] = 64'h0;
        do_req(e_bedrock_mem_uc_wr, 3, 40'h80, -1);
        wdata[0] = 64'hAAAAAAAA_AAAAAAAA;
        do_req(e_bedrock_mem_uc_wr, 0, 40'h83, -1);
        do_req(e_bedrock_mem_uc_rd, 3, 40'h80, -1);
        do_req(e_bedrock_mem_uc_rd, 0, 40'h83, -1);
        wdata[0] = 64'h12345678_9ABCDEF0;
        do_req(e_bedrock_mem_uc_wr, 1, 40'h86, -1);
        do_req(e_bedrock_mem_uc_rd, 2, 40'h84, -1);
        do_req(e_bedrock_mem_uc_rd, 1, 40'h82, -1);

        for (int k = 0; k < 8; k++) wdata[k] = 64'(k);
        do_req(e_bedrock_mem_wr, 6, 40'h1000, -1);
        do_req(e_bedrock_mem_rd, 6, 40'h1000, -1);
        do_req(e_bedrock_mem_rd, 6, 40'h1018, -1);

        bp_en = 1;
        @(posedge clk);
        #2;
        do_req(e_bedrock_mem_rd, 6, 40'h1000, -1);
        bp_en = 0;
        @(posedge clk);
        #2;

        wdata[0] = 64'hFFFFFFFF_FFFFFFFF;
        do_req(e_bedrock_mem_amo, 3, 40'h80, -1);
        do_req(e_bedrock_mem_uc_rd, 3, 40'h80, -1);

        wdata[0] = 64'h11223344_55667788;
        do_req(e_bedrock_mem_uc_wr, 3, 40'h0, -1);
        do_req(e_bedrock_mem_uc_rd, 3, 40'(els * 8), -1);

        for (int k = 0; k < 8; k++) wdata[k] = 64'hA0A0_0000_0000_0000 | 64'(k);
        do_req(e_bedrock_mem_wr, 6, 40'h2000, -1);
        for (int k = 0; k < 8; k++) wdata[k] = 64'hB0B0_0000_0000_0000 | 64'(k);
        do_req(e_bedrock_mem_wr, 6, 40'h2000, 4);
        do_req(e_bedrock_mem_rd, 6, 40'h2000, -1);

        for (int n = 0; n < 6; n++) begin
            int sz;
            logic [39:0] a;
            sz = $urandom_range(0, 3);
            a  = 40'h3000 | 40'($urandom_range(0, 63));
            wdata[0] = {$urandom, $urandom};
            do_req(e_bedrock_mem_uc_wr, 3, a & ~40'h7, -1);
            wdata[0] = {$urandom, $urandom};
            do_req(e_bedrock_mem_uc_wr, sz, a, -1);
            do_req(e_bedrock_mem_uc_rd, 3, a & ~40'h7, -1);
            do_req(e_bedrock_mem_uc_rd, sz, a, -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
